// File: rtl/galaxian_dl_ctrl.sv
// Galaxian ROM download controller: turns the data_io byte stream into per-ROM
// registered write strobes and owns the core reset around loads and user resets.
module galaxian_dl_ctrl #(
   parameter logic [7:0]  ROM_INDEX    = 8'd0,
   parameter logic [15:0] EXPECTED_LEN = 16'h6020,
   parameter int          HOLD_CYCLES  = 1024
) (
   input  logic        clk_sys,
   input  logic        res_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        user_reset,
   output logic        core_reset,
   output logic        pgm_we,
   output logic        gfx1k_we,
   output logic        gfx1h_we,
   output logic        prom_we,
   output logic [13:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        rom_loaded,
   output logic        dl_error
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_FULL = CW'(HOLD_CYCLES);

   typedef enum logic [1:0] {WAIT_ROM, LOAD, HOLD, RUN} state_t;

   state_t        state_q;
   logic [CW-1:0] holdCnt_q;
   logic [15:0]   byteCnt_q;
   logic          coreReset_q;
   logic          romLoaded_q;
   logic          dlError_q;
   logic [3:0]    we_q;
   logic [13:0]   wrAddr_q;
   logic [7:0]    wrData_q;

   logic          romStart;
   logic          winOpen;
   logic          inRange;
   logic          acceptWr;
   logic          badWr;
   logic [3:0]    we_d;
   logic [13:0]   wrAddr_d;

   // LOAD is only entered with download high, so download low while in LOAD is the falling edge.
   assign romStart = ioctl_download && (ioctl_index == ROM_INDEX);
   assign winOpen  = romStart || ((state_q == LOAD) && ioctl_download);
   assign inRange  = ioctl_addr < 25'(EXPECTED_LEN);
   assign acceptWr = winOpen && ioctl_wr && inRange;
   assign badWr    = winOpen && ioctl_wr && !inRange;

   always_comb begin
      we_d     = 4'b0000;
      wrAddr_d = '0;
      if (ioctl_addr[15:14] == 2'b00) begin
         we_d     = 4'b0001;
         wrAddr_d = ioctl_addr[13:0];
      end else if (ioctl_addr[15:12] == 4'h4) begin
         we_d     = 4'b0010;
         wrAddr_d = {2'b00, ioctl_addr[11:0]};
      end else if (ioctl_addr[15:12] == 4'h5) begin
         we_d     = 4'b0100;
         wrAddr_d = {2'b00, ioctl_addr[11:0]};
      end else begin
         we_d     = 4'b1000;
         wrAddr_d = {9'd0, ioctl_addr[4:0]};
      end
   end

   // A user reset parks the counter at HOLD_CYCLES so release lands the same number
   // of clocks after the request drops as after a download ends.
   always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) begin
         state_q     <= WAIT_ROM;
         holdCnt_q   <= '0;
         byteCnt_q   <= '0;
         coreReset_q <= 1'b1;
         romLoaded_q <= 1'b0;
         dlError_q   <= 1'b0;
         we_q        <= 4'b0000;
         wrAddr_q    <= '0;
         wrData_q    <= '0;
      end else begin
         we_q <= acceptWr ? we_d : 4'b0000;
         if (acceptWr) begin
            wrAddr_q <= wrAddr_d;
            wrData_q <= ioctl_dout;
         end
         if (romStart && (state_q != LOAD)) begin
            state_q     <= LOAD;
            coreReset_q <= 1'b1;
            byteCnt_q   <= acceptWr ? 16'd1 : 16'd0;
            dlError_q   <= badWr;
         end else begin
            case (state_q)
               WAIT_ROM: coreReset_q <= 1'b1;
               LOAD: begin
                  if (!ioctl_download) begin
                     state_q   <= HOLD;
                     holdCnt_q <= HOLD_LOAD;
                     if (byteCnt_q != EXPECTED_LEN) begin
                        dlError_q <= 1'b1;
                     end else if (!dlError_q) begin
                        romLoaded_q <= 1'b1;
                     end
                  end else begin
                     if (acceptWr && (byteCnt_q != 16'hFFFF)) begin
                        byteCnt_q <= byteCnt_q + 16'd1;
                     end
                     if (badWr) begin
                        dlError_q <= 1'b1;
                     end
                  end
               end
               HOLD: begin
                  if (user_reset) begin
                     holdCnt_q <= HOLD_FULL;
                  end else if (holdCnt_q == '0) begin
                     state_q     <= RUN;
                     coreReset_q <= 1'b0;
                  end else begin
                     holdCnt_q <= holdCnt_q - CW'(1);
                  end
               end
               RUN: begin
                  if (user_reset) begin
                     state_q     <= HOLD;
                     holdCnt_q   <= HOLD_FULL;
                     coreReset_q <= 1'b1;
                  end
               end
               default: state_q <= WAIT_ROM;
            endcase
         end
      end
   end

   assign core_reset = coreReset_q;
   assign pgm_we     = we_q[0];
   assign gfx1k_we   = we_q[1];
   assign gfx1h_we   = we_q[2];
   assign prom_we    = we_q[3];
   assign wr_addr    = wrAddr_q;
   assign wr_data    = wrData_q;
   assign rom_loaded = romLoaded_q;
   assign dl_error   = dlError_q;

endmodule

// File: tb/tb_galaxian_dl_ctrl.sv
// Self-checking bench for galaxian_dl_ctrl: strobes are scoreboarded against a
// region model, reset release timing is measured in clock edges.
module tb_galaxian_dl_ctrl;

   localparam int HOLD_CYCLES = 1024;

   logic        clk_sys = 1'b0;
   logic        res_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        user_reset = 1'b0;
   logic        core_reset;
   logic        pgm_we, gfx1k_we, gfx1h_we, prom_we;
   logic [13:0] wr_addr;
   logic [7:0]  wr_data;
   logic        rom_loaded, dl_error;

   galaxian_dl_ctrl #(
      .ROM_INDEX   (8'd0),
      .EXPECTED_LEN(16'h6020),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk_sys       (clk_sys),
      .res_n         (res_n),
      .ioctl_download(ioctl_download),
      .ioctl_index   (ioctl_index),
      .ioctl_wr      (ioctl_wr),
      .ioctl_addr    (ioctl_addr),
      .ioctl_dout    (ioctl_dout),
      .user_reset    (user_reset),
      .core_reset    (core_reset),
      .pgm_we        (pgm_we),
      .gfx1k_we      (gfx1k_we),
      .gfx1h_we      (gfx1h_we),
      .prom_we       (prom_we),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rom_loaded    (rom_loaded),
      .dl_error      (dl_error)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [3:0]  we;
      logic [13:0] addr;
      logic [7:0]  data;
      int          cyc;
   } rec_t;

   rec_t expQ[$];
   rec_t obsQ[$];
   int   cycleCnt = 0;
   int   cntPgm = 0, cntG1k = 0, cntG1h = 0, cntProm = 0;
   int   total = 0, bad = 0;
   logic [3:0] weVec;

   assign weVec = {prom_we, gfx1h_we, gfx1k_we, pgm_we};

   always @(posedge clk_sys) cycleCnt++;

   // Strobe monitor: every observed write is logged with the clock it appeared in.
   always @(negedge clk_sys) begin
      if (weVec != 4'b0000) begin
         rec_t r;
         r.we   = weVec;
         r.addr = wr_addr;
         r.data = wr_data;
         r.cyc  = cycleCnt;
         obsQ.push_back(r);
         cntPgm  += int'(pgm_we);
         cntG1k  += int'(gfx1k_we);
         cntG1h  += int'(gfx1h_we);
         cntProm += int'(prom_we);
      end
   end

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: sim time exceeded, bench did not complete");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [7:0] dataOf(input logic [24:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic rec_t model(input logic [24:0] a, input logic [7:0] d, input int cyc);
      rec_t r;
      r.data = d;
      r.cyc  = cyc;
      if (a < 25'h4000) begin
         r.we = 4'b0001; r.addr = a[13:0];
      end else if (a < 25'h5000) begin
         r.we = 4'b0010; r.addr = {2'b00, a[11:0]};
      end else if (a < 25'h6000) begin
         r.we = 4'b0100; r.addr = {2'b00, a[11:0]};
      end else begin
         r.we = 4'b1000; r.addr = {9'd0, a[4:0]};
      end
      return r;
   endfunction

   task automatic clear_mon();
      cntPgm = 0; cntG1k = 0; cntG1h = 0; cntProm = 0;
      expQ.delete();
      obsQ.delete();
   endtask

   // Drives one write cycle starting at a negedge; the strobe is due one clock later.
   task automatic put_write(input logic [24:0] a, input logic [7:0] d, input bit expectStrobe);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      if (expectStrobe) expQ.push_back(model(a, d, cycleCnt + 1));
      @(negedge clk_sys);
   endtask

   task automatic measure_release(output int n);
      n = 0;
      do begin
         @(posedge clk_sys);
         #1;
         n++;
      end while (core_reset && n < 3000);
   endtask

   task automatic drain(output int nBad, output string firstMsg);
      nBad = 0;
      firstMsg = "none";
      while (expQ.size() > 0) begin
         rec_t e, o;
         e = expQ.pop_front();
         if (obsQ.size() == 0) begin
            if (nBad == 0) firstMsg = $sformatf("no strobe, wanted we=%b addr=%h cyc=%0d", e.we, e.addr, e.cyc);
            nBad++;
         end else begin
            o = obsQ.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
               if (nBad == 0)
                  firstMsg = $sformatf("got we=%b addr=%h data=%h cyc=%0d want we=%b addr=%h data=%h cyc=%0d",
                                       o.we, o.addr, o.data, o.cyc, e.we, e.addr, e.data, e.cyc);
               nBad++;
            end
         end
      end
      if (obsQ.size() > 0) begin
         if (nBad == 0) firstMsg = $sformatf("unexpected strobe we=%b addr=%h", obsQ[0].we, obsQ[0].addr);
         nBad += obsQ.size();
         obsQ.delete();
      end
   endtask

   task automatic test_reset();
      res_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      total++; if (core_reset !== 1'b1) begin bad++; $display("[TB] FAIL reset_core_reset: got %b want 1", core_reset); end
      total++; if (weVec !== 4'b0000) begin bad++; $display("[TB] FAIL reset_we: got %b want 0000", weVec); end
      total++; if ({rom_loaded, dl_error} !== 2'b00) begin bad++; $display("[TB] FAIL reset_flags: got %b want 00", {rom_loaded, dl_error}); end
      total++; if ({wr_addr, wr_data} !== 22'd0) begin bad++; $display("[TB] FAIL reset_wr_bus: got %h want 0", {wr_addr, wr_data}); end
      res_n = 1'b1;
      clear_mon();
      ioctl_index = 8'd1;
      ioctl_download = 1'b1;
      for (int i = 0; i < 16; i++) put_write(25'(i * 3), 8'(i), 1'b0);
      ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
      repeat (100) @(negedge clk_sys);
      total++; if (core_reset !== 1'b1) begin bad++; $display("[TB] FAIL idle_core_reset: got %b want 1", core_reset); end
      total++; if (cntPgm + cntG1k + cntG1h + cntProm !== 0) begin bad++; $display("[TB] FAIL idle_no_strobe: got %0d want 0", cntPgm + cntG1k + cntG1h + cntProm); end
      total++; if (rom_loaded !== 1'b0) begin bad++; $display("[TB] FAIL idle_rom_loaded: got %b want 0", rom_loaded); end
   endtask

   task automatic test_short_image();
      int n, nb;
      string msg;
      clear_mon();
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      for (int a = 0; a < 'h5000; a++) put_write(25'(a), dataOf(25'(a)), 1'b1);
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      measure_release(n);
      drain(nb, msg);
      total++; if (nb !== 0) begin bad++; $display("[TB] FAIL short_scoreboard: got %0d bad records (%s) want 0", nb, msg); end
      total++; if (cntPgm !== 16384) begin bad++; $display("[TB] FAIL short_pgm_count: got %0d want 16384", cntPgm); end
      total++; if (cntG1k !== 4096) begin bad++; $display("[TB] FAIL short_1k_count: got %0d want 4096", cntG1k); end
      total++; if (cntG1h + cntProm !== 0) begin bad++; $display("[TB] FAIL short_other_count: got %0d want 0", cntG1h + cntProm); end
      total++; if (n !== HOLD_CYCLES + 1) begin bad++; $display("[TB] FAIL short_hold_edges: got %0d want %0d", n, HOLD_CYCLES + 1); end
      total++; if (dl_error !== 1'b1) begin bad++; $display("[TB] FAIL short_dl_error: got %b want 1", dl_error); end
      total++; if (rom_loaded !== 1'b0) begin bad++; $display("[TB] FAIL short_rom_loaded: got %b want 0", rom_loaded); end
   endtask

   task automatic test_range_error();
      int nb;
      string msg;
      clear_mon();
      @(negedge clk_sys);
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      put_write(25'h0010, 8'h11, 1'b1);
      total++; if (dl_error !== 1'b0) begin bad++; $display("[TB] FAIL range_error_cleared: got %b want 0", dl_error); end
      put_write(25'h6020, 8'h22, 1'b0);
      total++; if (dl_error !== 1'b1) begin bad++; $display("[TB] FAIL range_error_set: got %b want 1", dl_error); end
      put_write(25'h10000, 8'h33, 1'b0);
      put_write(25'h601F, 8'h44, 1'b1);
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      repeat (3) @(negedge clk_sys);
      drain(nb, msg);
      total++; if (nb !== 0) begin bad++; $display("[TB] FAIL range_scoreboard: got %0d bad records (%s) want 0", nb, msg); end
      total++; if (dl_error !== 1'b1) begin bad++; $display("[TB] FAIL range_dl_error_end: got %b want 1", dl_error); end
      total++; if (rom_loaded !== 1'b0) begin bad++; $display("[TB] FAIL range_rom_loaded: got %b want 0", rom_loaded); end
      total++; if (core_reset !== 1'b1) begin bad++; $display("[TB] FAIL range_in_hold: got %b want 1", core_reset); end
   endtask

   // Starts while the previous hold is still running, which must abandon it.
   task automatic test_full_image();
      int n, nb, s4005, s6010;
      bit found;
      rec_t r;
      string msg;
      clear_mon();
      s4005 = -1; s6010 = -1;
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      for (int a = 0; a < 'h6020; a++) begin
         if (a == 'h4005) s4005 = cycleCnt + 1;
         if (a == 'h6010) s6010 = cycleCnt + 1;
         put_write(25'(a), dataOf(25'(a)), 1'b1);
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      measure_release(n);
      found = 1'b0; r = '{we: 4'b0000, addr: 14'd0, data: 8'd0, cyc: 0};
      foreach (obsQ[i]) if (obsQ[i].cyc == s4005) begin found = 1'b1; r = obsQ[i]; end
      total++; if (!found || r.we !== 4'b0010 || r.addr !== 14'd5) begin bad++; $display("[TB] FAIL full_addr_4005: got found=%b we=%b addr=%h want we=0010 addr=0005", found, r.we, r.addr); end
      found = 1'b0; r = '{we: 4'b0000, addr: 14'd0, data: 8'd0, cyc: 0};
      foreach (obsQ[i]) if (obsQ[i].cyc == s6010) begin found = 1'b1; r = obsQ[i]; end
      total++; if (!found || r.we !== 4'b1000 || r.addr !== 14'h10) begin bad++; $display("[TB] FAIL full_addr_6010: got found=%b we=%b addr=%h want we=1000 addr=0010", found, r.we, r.addr); end
      drain(nb, msg);
      total++; if (nb !== 0) begin bad++; $display("[TB] FAIL full_scoreboard: got %0d bad records (%s) want 0", nb, msg); end
      total++; if (cntPgm !== 16384) begin bad++; $display("[TB] FAIL full_pgm_count: got %0d want 16384", cntPgm); end
      total++; if (cntG1k !== 4096) begin bad++; $display("[TB] FAIL full_1k_count: got %0d want 4096", cntG1k); end
      total++; if (cntG1h !== 4096) begin bad++; $display("[TB] FAIL full_1h_count: got %0d want 4096", cntG1h); end
      total++; if (cntProm !== 32) begin bad++; $display("[TB] FAIL full_prom_count: got %0d want 32", cntProm); end
      total++; if (n !== HOLD_CYCLES + 1) begin bad++; $display("[TB] FAIL full_hold_edges: got %0d want %0d", n, HOLD_CYCLES + 1); end
      total++; if ({rom_loaded, dl_error} !== 2'b10) begin bad++; $display("[TB] FAIL full_flags: got %b want 10", {rom_loaded, dl_error}); end
   endtask

   task automatic test_user_reset();
      int n;
      clear_mon();
      @(negedge clk_sys);
      total++; if (core_reset !== 1'b0) begin bad++; $display("[TB] FAIL ur_running: got %b want 0", core_reset); end
      user_reset = 1'b1;
      @(posedge clk_sys); #1;
      total++; if (core_reset !== 1'b1) begin bad++; $display("[TB] FAIL ur_next_edge: got %b want 1", core_reset); end
      repeat (49) @(posedge clk_sys);
      @(negedge clk_sys);
      total++; if (core_reset !== 1'b1) begin bad++; $display("[TB] FAIL ur_held: got %b want 1", core_reset); end
      user_reset = 1'b0;
      measure_release(n);
      total++; if (n !== HOLD_CYCLES + 1) begin bad++; $display("[TB] FAIL ur_hold_edges: got %0d want %0d", n, HOLD_CYCLES + 1); end
      total++; if (cntPgm + cntG1k + cntG1h + cntProm !== 0) begin bad++; $display("[TB] FAIL ur_no_strobe: got %0d want 0", cntPgm + cntG1k + cntG1h + cntProm); end
   endtask

   task automatic test_other_index();
      int crHigh, nb;
      string msg;
      clear_mon();
      crHigh = 0;
      @(negedge clk_sys);
      ioctl_index = 8'd1;
      ioctl_download = 1'b1;
      for (int i = 0; i < 64; i++) begin
         put_write(25'(i * 'h181), 8'(i), 1'b0);
         if (core_reset !== 1'b0) crHigh++;
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
      repeat (5) begin
         @(negedge clk_sys);
         if (core_reset !== 1'b0) crHigh++;
      end
      drain(nb, msg);
      total++; if (crHigh !== 0) begin bad++; $display("[TB] FAIL idx1_core_reset: got %0d high samples want 0", crHigh); end
      total++; if (nb !== 0) begin bad++; $display("[TB] FAIL idx1_no_strobe: got %0d strobes (%s) want 0", nb, msg); end
      total++; if (rom_loaded !== 1'b1) begin bad++; $display("[TB] FAIL idx1_rom_loaded: got %b want 1", rom_loaded); end
   endtask

   task automatic test_reset_mid_load();
      clear_mon();
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      put_write(25'h0000, 8'h01, 1'b0);
      put_write(25'h0123, 8'hA7, 1'b0);
      total++; if (weVec !== 4'b0001 || wr_addr !== 14'h123) begin bad++; $display("[TB] FAIL midload_strobe: got we=%b addr=%h want we=0001 addr=0123", weVec, wr_addr); end
      #2 res_n = 1'b0;
      #1;
      total++; if (weVec !== 4'b0000) begin bad++; $display("[TB] FAIL midload_async_we: got %b want 0000", weVec); end
      total++; if ({wr_addr, wr_data} !== 22'd0) begin bad++; $display("[TB] FAIL midload_async_bus: got %h want 0", {wr_addr, wr_data}); end
      total++; if ({core_reset, rom_loaded, dl_error} !== 3'b100) begin bad++; $display("[TB] FAIL midload_async_flags: got %b want 100", {core_reset, rom_loaded, dl_error}); end
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      @(negedge clk_sys);
      res_n = 1'b1;
      repeat (20) @(negedge clk_sys);
      total++; if ({core_reset, rom_loaded} !== 2'b10) begin bad++; $display("[TB] FAIL midload_after: got %b want 10", {core_reset, rom_loaded}); end
   endtask

   initial begin
      $display("[TB] starting galaxian_dl_ctrl bench");
      test_reset();
      test_short_image();
      test_range_error();
      test_full_image();
      test_user_reset();
      test_other_index();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
